// File: rtl/permutation_round_ctrl.sv
// Sequencer for the iterative permutation datapath: load, R rounds with optional flush
// bubbles, then a held result behind a valid/ack handshake. Abortable at any point.
module permutation_round_ctrl #(
  parameter int unsigned NUM_ROUNDS   = 24,
  parameter int unsigned ROUND_W      = 5,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned FLUSH_W      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ROUND_W-1:0] rounds_cfg,
  input  logic               abort,
  input  logic               out_ack,
  output logic               ready,
  output logic               input_sel,
  output logic               permutation_sel,
  output logic               ld_x,
  output logic [ROUND_W-1:0] round_idx,
  output logic               out_valid,
  output logic               done
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StInit   = 3'd1;
  localparam logic [2:0] StLoadIn = 3'd2;
  localparam logic [2:0] StPerm   = 3'd3;
  localparam logic [2:0] StFlush  = 3'd4;
  localparam logic [2:0] StHold   = 3'd5;

  localparam logic [ROUND_W-1:0] LastDefault = ROUND_W'(NUM_ROUNDS - 1);
  localparam logic [FLUSH_W-1:0] FlushLast   =
      (FLUSH_CYCLES > 0) ? FLUSH_W'(FLUSH_CYCLES - 1) : '0;

  logic [2:0]         state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [ROUND_W-1:0] last_q, last_d;   // index of the final round (R-1)
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic [ROUND_W-1:0] cfg_last;

  // Zero or over-range round counts fall back to the full round count.
  always_comb begin
    if (rounds_cfg == '0 || 32'(rounds_cfg) > NUM_ROUNDS) begin
      cfg_last = LastDefault;
    end else begin
      cfg_last = rounds_cfg - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    last_d  = last_q;
    flush_d = flush_q;
    if (abort && state_q != StIdle) begin
      state_d = StIdle;
      round_d = '0;
      flush_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StInit;
            last_d  = cfg_last;
            round_d = '0;
          end
        end
        StInit: begin
          round_d = '0;
          flush_d = '0;
          state_d = StLoadIn;
        end
        StLoadIn: state_d = StPerm;
        StPerm: begin
          if (round_q == last_q) begin
            state_d = StHold;
          end else begin
            round_d = round_q + 1'b1;
            flush_d = '0;
            state_d = (FLUSH_CYCLES > 0) ? StFlush : StPerm;
          end
        end
        StFlush: begin
          if (flush_q == FlushLast) begin
            flush_d = '0;
            state_d = StPerm;
          end else begin
            flush_d = flush_q + 1'b1;
          end
        end
        StHold: begin
          if (out_ack) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      round_q <= '0;
      last_q  <= LastDefault;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      last_q  <= last_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    ready           = (state_q == StIdle);
    input_sel       = (state_q == StLoadIn);
    permutation_sel = (state_q == StPerm);
    ld_x            = (state_q == StLoadIn) || (state_q == StPerm);
    out_valid       = (state_q == StHold);
    done            = (state_q == StHold) && out_ack && !abort;
  end

  assign round_idx = round_q;

endmodule

// File: tb/tb_permutation_round_ctrl.sv
// Random-stimulus bench: two controllers (one flush bubble / no flush) against a
// cycle-count job model derived from the round schedule arithmetic.
module tb_permutation_round_ctrl;

  localparam int unsigned NR = 4;
  localparam int unsigned RW = 3;

  logic          clk = 1'b0;
  logic          rst, start, abort, out_ack;
  logic [RW-1:0] rounds_cfg;
  logic [1:0]    ready, input_sel, perm_sel, ld_x, out_valid, done;
  logic [RW-1:0] round_idx [2];

  int n_checks = 0;
  int n_errs   = 0;

  // Model state per instance: index 0 has one flush bubble, index 1 none.
  bit m_busy     [2];
  int m_t        [2];
  int m_r        [2];
  int m_idle_idx [2];

  always #5 clk = ~clk;

  permutation_round_ctrl #(
    .NUM_ROUNDS(NR), .ROUND_W(RW), .FLUSH_CYCLES(1), .FLUSH_W(2)
  ) u_dut_f1 (
    .clk(clk), .rst(rst), .start(start), .rounds_cfg(rounds_cfg), .abort(abort),
    .out_ack(out_ack), .ready(ready[0]), .input_sel(input_sel[0]),
    .permutation_sel(perm_sel[0]), .ld_x(ld_x[0]), .round_idx(round_idx[0]),
    .out_valid(out_valid[0]), .done(done[0])
  );

  permutation_round_ctrl #(
    .NUM_ROUNDS(NR), .ROUND_W(RW), .FLUSH_CYCLES(0), .FLUSH_W(2)
  ) u_dut_f0 (
    .clk(clk), .rst(rst), .start(start), .rounds_cfg(rounds_cfg), .abort(abort),
    .out_ack(out_ack), .ready(ready[1]), .input_sel(input_sel[1]),
    .permutation_sel(perm_sel[1]), .ld_x(ld_x[1]), .round_idx(round_idx[1]),
    .out_valid(out_valid[1]), .done(done[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Phase codes: 0 idle, 1 init, 2 load, 3 perm, 4 flush, 5 hold.
  function automatic int phase_of(input int d, output int idx);
    int f, hs, u;
    f = (d == 0) ? 1 : 0;
    idx = 0;
    if (!m_busy[d]) begin
      idx = m_idle_idx[d];
      return 0;
    end
    if (m_t[d] == 1) return 1;
    if (m_t[d] == 2) return 2;
    hs = 3 + m_r[d] + (m_r[d] - 1) * f;
    if (m_t[d] >= hs) begin
      idx = m_r[d] - 1;
      return 5;
    end
    u = m_t[d] - 3;
    if (u % (f + 1) == 0) begin
      idx = u / (f + 1);
      return 3;
    end
    idx = u / (f + 1) + 1;
    return 4;
  endfunction

  function automatic logic [5:0] flags_of(input int ph);
    case (ph)
      0:       return 6'b100000;
      2:       return 6'b010100;
      3:       return 6'b001100;
      5:       return {4'b0000, 1'b1, out_ack && !abort};
      default: return 6'b000000;
    endcase
  endfunction

  task automatic check_cycle(input int cyc);
    int ph, idx;
    for (int d = 0; d < 2; d++) begin
      ph = phase_of(d, idx);
      check_eq($sformatf("flags[%0d] cyc %0d ph %0d", d, cyc, ph),
               32'({ready[d], input_sel[d], perm_sel[d], ld_x[d], out_valid[d], done[d]}),
               32'(flags_of(ph)));
      check_eq($sformatf("round_idx[%0d] cyc %0d ph %0d", d, cyc, ph),
               32'(round_idx[d]), 32'(idx));
    end
  endtask

  task automatic step_model();
    int ph, idx;
    for (int d = 0; d < 2; d++) begin
      ph = phase_of(d, idx);
      if (!rst) begin
        m_busy[d] = 1'b0;
        m_idle_idx[d] = 0;
      end else if (m_busy[d] && abort) begin
        m_busy[d] = 1'b0;
        m_idle_idx[d] = 0;
      end else if (!m_busy[d]) begin
        if (start) begin
          m_busy[d] = 1'b1;
          m_t[d] = 1;
          m_r[d] = (rounds_cfg == 0 || int'(rounds_cfg) > int'(NR)) ? int'(NR)
                                                                     : int'(rounds_cfg);
        end
      end else if (ph == 5 && out_ack) begin
        m_busy[d] = 1'b0;
        m_idle_idx[d] = m_r[d] - 1;
      end else begin
        m_t[d]++;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    out_ack = 1'b0;
    rounds_cfg = '0;
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0;
      m_t[d] = 0;
      m_r[d] = NR;
      m_idle_idx[d] = 0;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    start = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      check_cycle(cyc);
      step_model();
      @(posedge clk);
      #1;
      start      = ($urandom % 3) != 0;
      abort      = ($urandom % 40) == 0;
      out_ack    = ($urandom % 4) == 0;
      rst        = ($urandom % 150) != 0;
      rounds_cfg = RW'($urandom % 8);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
